// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges execute and load results into one register-file
// write per cycle. Results are serialised in program order through a small
// FIFO, and a per-register busy scoreboard is published for decode stalls.
// Optional feature macro: REGFILE_WB_FWD_EN builds the forwarding comparators;
// without it, the fwd_* outputs are tied to zero.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_adrs,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_adrs,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic [4:0]  rd_adrs_a,
    input  logic [4:0]  rd_adrs_b,
    input  logic [4:0]  rd_adrs_c,
    output logic        wr_en,
    output logic [4:0]  wr_adrs,
    output logic [31:0] wr_data,
    output logic [31:0] busy,
    output logic        fwd_hit_a,
    output logic        fwd_hit_b,
    output logic        fwd_hit_c,
    output logic [31:0] fwd_data_a,
    output logic [31:0] fwd_data_b,
    output logic [31:0] fwd_data_c
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       q_adrs [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    logic        ex_acc;
    logic        mem_acc;
    logic        iss_en;
    logic [4:0]  iss_adrs;
    logic [31:0] iss_data;
    logic        pop;
    logic        push0_en;
    logic [4:0]  push0_adrs;
    logic [31:0] push0_data;
    logic        push1_en;
    logic [4:0]  push1_adrs;
    logic [31:0] push1_data;
    logic [1:0]  n_push;
    logic [31:0] busy_c;

    // Readiness looks at occupancy only; mem keeps one slot spare for ex.
    assign ex_ready  = (cnt <= CNT_W'(DEPTH - 1));
    assign mem_ready = (cnt <= CNT_W'(DEPTH - 2));

    // Writes to $0 are accepted but dropped here, so they never queue or issue.
    assign ex_acc  = ex_valid && ex_ready && (ex_adrs != 5'd0);
    assign mem_acc = mem_valid && mem_ready && (mem_adrs != 5'd0);

    // Pick the oldest candidate (head, then load, then ex) and queue the rest.
    always_comb begin
        iss_en     = 1'b0;
        iss_adrs   = wr_adrs;
        iss_data   = wr_data;
        pop        = 1'b0;
        push0_en   = 1'b0;
        push0_adrs = mem_adrs;
        push0_data = mem_data;
        push1_en   = 1'b0;
        push1_adrs = ex_adrs;
        push1_data = ex_data;
        if (cnt != '0) begin
            iss_en   = 1'b1;
            iss_adrs = q_adrs[head];
            iss_data = q_data[head];
            pop      = 1'b1;
            if (mem_acc) begin
                push0_en = 1'b1;
                push1_en = ex_acc;
            end else if (ex_acc) begin
                push0_en   = 1'b1;
                push0_adrs = ex_adrs;
                push0_data = ex_data;
            end
        end else if (mem_acc) begin
            iss_en   = 1'b1;
            iss_adrs = mem_adrs;
            iss_data = mem_data;
            if (ex_acc) begin
                push0_en   = 1'b1;
                push0_adrs = ex_adrs;
                push0_data = ex_data;
            end
        end else if (ex_acc) begin
            iss_en   = 1'b1;
            iss_adrs = ex_adrs;
            iss_data = ex_data;
        end
        n_push = {1'b0, push0_en} + {1'b0, push1_en};
    end

    // FIFO storage; payload needs no reset because occupancy qualifies it.
    always_ff @(posedge clk_cpu) begin
        if (push0_en) begin
            q_adrs[tail] <= push0_adrs;
            q_data[tail] <= push0_data;
        end
        if (push1_en) begin
            q_adrs[tail + PTR_W'(1)] <= push1_adrs;
            q_data[tail + PTR_W'(1)] <= push1_data;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_adrs <= 5'd0;
            wr_data <= 32'd0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(n_push);
            cnt   <= cnt + CNT_W'(n_push) - CNT_W'(pop);
            wr_en <= iss_en;
            if (iss_en) begin
                wr_adrs <= iss_adrs;
                wr_data <= iss_data;
            end
        end
    end

    // Scoreboard: a register is busy while queued or sitting on the write port.
    always_comb begin
        busy_c = '0;
        if (wr_en) busy_c[wr_adrs] = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < cnt) busy_c[q_adrs[head + PTR_W'(k)]] = 1'b1;
        end
        busy_c[0] = 1'b0;
    end
    assign busy = busy_c;

`ifdef REGFILE_WB_FWD_EN
    logic [4:0]  rd_sel  [3];
    logic        hit_c   [3];
    logic [31:0] dat_c   [3];

    assign rd_sel[0] = rd_adrs_a;
    assign rd_sel[1] = rd_adrs_b;
    assign rd_sel[2] = rd_adrs_c;

    // Forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            hit_c[p] = 1'b0;
            dat_c[p] = 32'd0;
            if (rd_sel[p] != 5'd0) begin
                if (wr_en && (wr_adrs == rd_sel[p])) begin
                    hit_c[p] = 1'b1;
                    dat_c[p] = wr_data;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    if ((CNT_W'(k) < cnt) && (q_adrs[head + PTR_W'(k)] == rd_sel[p])) begin
                        hit_c[p] = 1'b1;
                        dat_c[p] = q_data[head + PTR_W'(k)];
                    end
                end
            end
        end
    end

    assign fwd_hit_a  = hit_c[0];
    assign fwd_hit_b  = hit_c[1];
    assign fwd_hit_c  = hit_c[2];
    assign fwd_data_a = dat_c[0];
    assign fwd_data_b = dat_c[1];
    assign fwd_data_c = dat_c[2];
`else
    logic unused_rd;
    assign unused_rd  = ^{rd_adrs_a, rd_adrs_b, rd_adrs_c};
    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_hit_c  = 1'b0;
    assign fwd_data_a = 32'd0;
    assign fwd_data_b = 32'd0;
    assign fwd_data_c = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a queue-based program-order model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic        ex_valid, mem_valid;
    logic [4:0]  ex_adrs, mem_adrs;
    logic [31:0] ex_data, mem_data;
    logic        ex_ready, mem_ready;
    logic [4:0]  rd_adrs_a, rd_adrs_b, rd_adrs_c;
    logic        wr_en;
    logic [4:0]  wr_adrs;
    logic [31:0] wr_data;
    logic [31:0] busy;
    logic        fwd_hit_a, fwd_hit_b, fwd_hit_c;
    logic [31:0] fwd_data_a, fwd_data_b, fwd_data_c;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_cpu(clk_cpu), .reset(reset),
        .ex_valid(ex_valid), .ex_adrs(ex_adrs), .ex_data(ex_data), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_adrs(mem_adrs), .mem_data(mem_data), .mem_ready(mem_ready),
        .rd_adrs_a(rd_adrs_a), .rd_adrs_b(rd_adrs_b), .rd_adrs_c(rd_adrs_c),
        .wr_en(wr_en), .wr_adrs(wr_adrs), .wr_data(wr_data), .busy(busy),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_hit_c(fwd_hit_c),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .fwd_data_c(fwd_data_c)
    );

    initial forever #5 clk_cpu = ~clk_cpu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        pend[$];
    logic        m_wr_en   = 1'b0;
    logic [4:0]  m_wr_adrs = 5'd0;
    logic [31:0] m_wr_data = 32'd0;

    initial forever begin
        @(posedge clk_cpu or posedge reset);
        if (reset) begin
            pend.delete();
            m_wr_en = 1'b0; m_wr_adrs = 5'd0; m_wr_data = 32'd0;
        end else begin
            int  n;
            logic ma, ea;
            ent_t e;
            n  = pend.size();
            ma = mem_valid && (n <= DEPTH - 2) && (mem_adrs != 5'd0);
            ea = ex_valid && (n <= DEPTH - 1) && (ex_adrs != 5'd0);
            if (ma) pend.push_back({mem_adrs, mem_data});
            if (ea) pend.push_back({ex_adrs, ex_data});
            if (pend.size() > 0) begin
                e = pend.pop_front();
                m_wr_en = 1'b1; m_wr_adrs = e.a; m_wr_data = e.d;
            end else begin
                m_wr_en = 1'b0;
            end
        end
    end

    task automatic fwd_exp(input logic [4:0] rd, output logic hit, output logic [31:0] d);
        hit = 1'b0; d = 32'd0;
`ifdef REGFILE_WB_FWD_EN
        if (rd != 5'd0) begin
            if (m_wr_en && m_wr_adrs == rd) begin hit = 1'b1; d = m_wr_data; end
            foreach (pend[i]) if (pend[i].a == rd) begin hit = 1'b1; d = pend[i].d; end
        end
`endif
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        logic [31:0] be;
        logic        h;
        logic [31:0] d;
        @(negedge clk_cpu);
        be = '0;
        if (m_wr_en) be[m_wr_adrs] = 1'b1;
        foreach (pend[i]) be[pend[i].a] = 1'b1;
        be[0] = 1'b0;
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        chk("wr_adrs", 32'(wr_adrs), 32'(m_wr_adrs));
        chk("wr_data", wr_data, m_wr_data);
        chk("busy", busy, be);
        chk("ex_ready", 32'(ex_ready), 32'(pend.size() <= DEPTH - 1));
        chk("mem_ready", 32'(mem_ready), 32'(pend.size() <= DEPTH - 2));
        fwd_exp(rd_adrs_a, h, d);
        chk("fwd_hit_a", 32'(fwd_hit_a), 32'(h)); chk("fwd_data_a", fwd_data_a, d);
        fwd_exp(rd_adrs_b, h, d);
        chk("fwd_hit_b", 32'(fwd_hit_b), 32'(h)); chk("fwd_data_b", fwd_data_b, d);
        fwd_exp(rd_adrs_c, h, d);
        chk("fwd_hit_c", 32'(fwd_hit_c), 32'(h)); chk("fwd_data_c", fwd_data_c, d);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic ev, input logic [4:0] ea, input logic [31:0] ed);
        mem_valid = mv; mem_adrs = ma; mem_data = md;
        ex_valid = ev; ex_adrs = ea; ex_data = ed;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int n_wr, mi, ei;
        logic saw_stall, macc, eacc;
        reset = 1'b0;
        idle();
        rd_adrs_a = 5'd5; rd_adrs_b = 5'd9; rd_adrs_c = 5'd8;
        #1 reset = 1'b1;
        tick(); tick();
        #2;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_adrs", 32'(wr_adrs), 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_fwd_hit_a", 32'(fwd_hit_a), 32'd0);
        tick();
        reset = 1'b0;

        // single ex write
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        tick(); idle(); #2;
        chk("t1_wr_en", 32'(wr_en), 32'd1);
        chk("t1_wr_adrs", 32'(wr_adrs), 32'd5);
        chk("t1_wr_data", wr_data, 32'h1234);
        chk("t1_busy5", 32'(busy[5]), 32'd1);
        tick(); #2;
        chk("t1_busy5_clr", 32'(busy[5]), 32'd0);
        chk("t1_wr_en_clr", 32'(wr_en), 32'd0);

        // simultaneous mem and ex: load first
        drive(1'b1, 5'd8, 32'hAA, 1'b1, 5'd9, 32'hBB);
        tick(); idle(); #2;
        chk("t2_adrs1", 32'(wr_adrs), 32'd8);
        chk("t2_data1", wr_data, 32'hAA);
        chk("t2_busy9a", 32'(busy[9]), 32'd1);
        tick(); #2;
        chk("t2_adrs2", 32'(wr_adrs), 32'd9);
        chk("t2_data2", wr_data, 32'hBB);
        chk("t2_busy9b", 32'(busy[9]), 32'd1);
        chk("t2_busy8", 32'(busy[8]), 32'd0);
        tick(); #2;

        // $0 filter
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick(); idle(); #2;
        chk("t3_wr_en", 32'(wr_en), 32'd0);
        chk("t3_busy", busy, 32'd0);
        tick(); #2;

        // fill: both paths valid every cycle, upstream holds when not accepted
        n_wr = 0; mi = 0; ei = 0; saw_stall = 1'b0;
        for (int t = 0; t < 40 && (mi < 6 || ei < 6); t++) begin
            drive(mi < 6, 5'(1 + 2 * mi), 32'h100 + 32'(mi),
                  ei < 6, 5'(2 + 2 * ei), 32'h200 + 32'(ei));
            macc = mem_valid && mem_ready;
            eacc = ex_valid && ex_ready;
            if (mem_valid && !mem_ready) saw_stall = 1'b1;
            tick();
            if (macc) mi++;
            if (eacc) ei++;
            #2;
            if (wr_en) n_wr++;
        end
        idle();
        for (int t = 0; t < 8; t++) begin
            tick(); #2;
            if (wr_en) n_wr++;
        end
        chk("t4_mem_sent", 32'(mi), 32'd6);
        chk("t4_ex_sent", 32'(ei), 32'd6);
        chk("t4_mem_stall_seen", 32'(saw_stall), 32'd1);
        chk("t4_writes", 32'(n_wr), 32'd12);

        // reset while three entries are queued
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, 5'(20 + 2 * t), 32'h300 + 32'(t), 1'b1, 5'(21 + 2 * t), 32'h400 + 32'(t));
            tick();
        end
        idle();
        reset = 1'b1;
        #2;
        chk("t5_wr_en", 32'(wr_en), 32'd0);
        chk("t5_busy", busy, 32'd0);
        chk("t5_ex_ready", 32'(ex_ready), 32'd1);
        chk("t5_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        reset = 1'b0;
        n_wr = 0;
        for (int t = 0; t < 5; t++) begin
            tick(); #2;
            if (wr_en) n_wr++;
        end
        chk("t5_no_stale_writes", 32'(n_wr), 32'd0);

        // forwarding: the younger $3 value wins
        rd_adrs_a = 5'd3; rd_adrs_b = 5'd3;
        drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd3, 32'd2);
        tick(); idle(); #2;
`ifdef REGFILE_WB_FWD_EN
        chk("t6_fwd_hit_b", 32'(fwd_hit_b), 32'd1);
        chk("t6_fwd_data_b", fwd_data_b, 32'd2);
`else
        chk("t6_fwd_hit_b", 32'(fwd_hit_b), 32'd0);
        chk("t6_fwd_data_b", fwd_data_b, 32'd0);
`endif
        chk("t6_busy3", 32'(busy[3]), 32'd1);
        chk("t6_first_data", wr_data, 32'd1);
        tick(); #2;
        chk("t6_last_wins", wr_data, 32'd2);
        tick(); tick(); #2;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Write-back arbiter between the execute and memory stages and the single write port of `register_file`.
- Accepts results from the execute (ALU) path and the memory (load) path.
- Serialises the results in program order through a small FIFO.
- Drives at most one registered write per cycle into the register file.
- Publishes a per-register busy scoreboard that decode uses for hazard stalls.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `clk_cpu` in 1 CPU clock
- `reset` in 1 asynchronous, active-high
- `ex_valid` in 1 execute result present
- `ex_adrs` in 5 execute destination register
- `ex_data` in 32 execute result
- `ex_ready` out 1 execute result accepted this cycle; upstream holds when low
- `mem_valid` in 1 load result present
- `mem_adrs` in 5 load destination register
- `mem_data` in 32 load result
- `mem_ready` out 1 load result accepted this cycle
- `rd_adrs_a`, `rd_adrs_b`, `rd_adrs_c` in 5 each; decode read addresses, used by forwarding only
- `wr_en` out 1 register-file write enable (registered)
- `wr_adrs` out 5 register-file write address (registered)
- `wr_data` out 32 register-file write data (registered)
- `busy` out 32 bit r set while a write to r is queued or on `wr_*`
- `fwd_hit_a`/`_b`/`_c` out 1 each; forwarding hit
- `fwd_data_a`/`_b`/`_c` out 32 each; forwarded value

## Operation
- **Handshake**
  - A transfer occurs when valid && ready on the same edge.
  - `cnt` is the FIFO occupancy.
  - `ex_ready = (cnt <= DEPTH-1)`, computed from `cnt` only (ignores same-cycle drain).
  - `mem_ready = (cnt <= DEPTH-2)`, which reserves one slot for a simultaneous ex result.
- **Register $0**
  - An accepted transfer with adrs == 0 is consumed and discarded.
  - It is never queued, never issued and never marks busy.
- **Program order, oldest first:** FIFO head, then accepted mem, then accepted ex.
  - The load is older than the ex result issued alongside it.
- **Each cycle**
  - The oldest candidate is issued into `wr_*`.
  - Remaining accepted candidates are enqueued in order: 0, 1 or 2 pushes.
  - One pop occurs when the head is issued.
  - If there is no candidate, `wr_en` goes to 0; `wr_adrs`/`wr_data` hold their previous value.
- **FIFO**
  - Head/tail pointers of width log2(DEPTH) wrap modulo DEPTH.
  - `cnt` has width log2(DEPTH)+1.
  - `cnt_next = cnt + pushes - pops`, never exceeding DEPTH by construction.
- **Scoreboard**
  - `busy[r]` = OR over valid FIFO entries of (adrs == r), OR (`wr_en` && `wr_adrs` == r).
  - Combinational from registered state.
  - `busy[0]` is always 0.
- **Forwarding**
  - A read address matches when it is non-zero and equals the adrs of `wr_*` (with `wr_en`) or of any valid entry.
  - The youngest matching entry supplies the data.
  - Age order, youngest first: FIFO tail-1 … head, then `wr_*`.

## Timing
- Latency is 1 cycle from an accepted transfer to `wr_en` when the FIFO is empty and no older candidate exists.
- Otherwise each entry ahead adds 1 cycle.
- Throughput is one register write per cycle.
- **Reset values**
  - `wr_en` = 0, `wr_adrs` = 0, `wr_data` = 0.
  - `cnt` = 0, pointers = 0, `busy` = 0.
  - `ex_ready` = 1, `mem_ready` = 1.
  - All `fwd_hit_*` = 0, all `fwd_data_*` = 0.
- Reset asserted mid-operation discards every queued and in-flight write. No write is issued on the edge reset deasserts.
- **Full** (`cnt == DEPTH`): `ex_ready` = 0 and `mem_ready` = 0. The head still drains in that cycle, and ready reasserts the following cycle.
- **`cnt == DEPTH-1`**: only ex is accepted.
- **Two pushes with the head issued** (same cycle): `cnt` rises by 1.
- **Same register queued more than once**: the writes are issued in order, so the last one wins in the register file.

## Configuration
- **`REGFILE_WB_FWD_EN` defined**: the forwarding comparators are built as described in Operation.
- **`REGFILE_WB_FWD_EN` undefined**:
  - `fwd_hit_*` are tied to 0 and `fwd_data_*` to 0; the read-address inputs are ignored.
  - Scoreboard and arbitration are unchanged.
  - The port list is identical in both builds.

## Test plan
- **Single ex write:** after reset, ex `$5 = 0x1234`.
  - Next cycle: `wr_en` = 1, `wr_adrs` = 5, `wr_data` = 0x1234, `busy[5]` = 1.
  - One cycle later: `busy[5]` = 0.
- **Simultaneous mem and ex:** mem `$8 = 0xAA` and ex `$9 = 0xBB` in the same cycle.
  - `$8` is written at +1 and `$9` at +2.
  - `busy[9]` is high for both cycles.
- **$0 filter:** ex `$0 = 0xFFFFFFFF`.
  - `wr_en` stays 0 and `busy` stays 0.
- **Fill with DEPTH=4:** mem and ex both valid every cycle with distinct registers.
  - `mem_ready` drops once `cnt` reaches 3; `ex_ready` drops at 4.
  - All accepted values appear on `wr_*` exactly once, in order, with no loss.
- **Reset mid-operation:** reset while `cnt` = 3.
  - `wr_en` = 0, `busy` = 0, both readies = 1.
  - None of the queued writes appears afterwards.
- **Forwarding, with `REGFILE_WB_FWD_EN`:** queue `$3 = 1` then `$3 = 2`, with `rd_adrs_b` = 3.
  - `fwd_hit_b` = 1 and `fwd_data_b` = 2.
  - Without the macro, `fwd_hit_b` = 0.
